// File: rtl/walk_register.sv
// Pedestrian walk-request latch: sticky pending flag, set pulse, saturating request and age counters.
// Optional WALK_REGISTER_SYNC_EN puts a 2-flop synchronizer on walkRequest_in.
module walk_register #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned AGE_W = 12
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             walkRequest_in,
  input  logic             walkRegister_reset,
  output logic             walkRegister_status,
  output logic             walkRegister_set,
  output logic [CNT_W-1:0] walkRegister_count,
  output logic [AGE_W-1:0] walkRegister_age
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic             req_eff_c;
  logic             status_q, status_d;
  logic             set_q, set_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             rise_c;

`ifdef WALK_REGISTER_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-stage synchronizer for the asynchronous push-button level
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= walkRequest_in;
      sync2_q <= sync1_q;
    end
  end

  assign req_eff_c = sync2_q;
`else
  assign req_eff_c = walkRequest_in;
`endif

  // Next-state: clear beats request, otherwise the flag is sticky
  always_comb begin
    status_d = status_q;
    set_d    = 1'b0;
    count_d  = count_q;
    age_d    = age_q;

    if (walkRegister_reset) begin
      status_d = 1'b0;
    end else if (req_eff_c) begin
      status_d = 1'b1;
    end

    rise_c = status_d & ~status_q;
    set_d  = rise_c;

    if (rise_c && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end

    // Age restarts on the set edge and is held at zero while idle
    if (!status_d || rise_c) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      status_q <= 1'b0;
      set_q    <= 1'b0;
      count_q  <= '0;
      age_q    <= '0;
    end else begin
      status_q <= status_d;
      set_q    <= set_d;
      count_q  <= count_d;
      age_q    <= age_d;
    end
  end

  assign walkRegister_status = status_q;
  assign walkRegister_set    = set_q;
  assign walkRegister_count  = count_q;
  assign walkRegister_age    = age_q;

endmodule

// File: tb/tb_walk_register.sv
// Directed self-checking bench for walk_register; adapts request latency when WALK_REGISTER_SYNC_EN is defined.
module tb_walk_register;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned AGE_W = 12;
  localparam int unsigned VW    = CNT_W + AGE_W + 2;
`ifdef WALK_REGISTER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             sys_reset = 1'b1;
  logic             walkRequest_in = 1'b0;
  logic             walkRegister_reset = 1'b0;
  logic             walkRegister_status;
  logic             walkRegister_set;
  logic [CNT_W-1:0] walkRegister_count;
  logic [AGE_W-1:0] walkRegister_age;

  int tests_run = 0;
  int tests_failed = 0;

  logic [VW-1:0] obs;
  logic [VW-1:0] exp_v;

  walk_register #(.CNT_W(CNT_W), .AGE_W(AGE_W)) dut (
    .clk                 (clk),
    .sys_reset           (sys_reset),
    .walkRequest_in      (walkRequest_in),
    .walkRegister_reset  (walkRegister_reset),
    .walkRegister_status (walkRegister_status),
    .walkRegister_set    (walkRegister_set),
    .walkRegister_count  (walkRegister_count),
    .walkRegister_age    (walkRegister_age)
  );

  always #5 clk = ~clk;

  assign obs = {walkRegister_status, walkRegister_set, walkRegister_count, walkRegister_age};

  function automatic logic [VW-1:0] pack(input logic s, input logic p, input int c, input int a);
    return {s, p, CNT_W'(c), AGE_W'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    sys_reset = 1'b0;
    walkRequest_in = 1'b1;
    #1;
    exp_v = pack(0, 0, 0, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_async: got %h want %h", obs, exp_v);
    end
    repeat (3) tick();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h want %h", obs, exp_v);
    end
    walkRequest_in = 1'b0;
    sys_reset = 1'b1;
    tick();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_latency();
    walkRequest_in = 1'b1;
    #1;
    exp_v = pack(0, 0, 0, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL no_comb_path: got %h want %h", obs, exp_v);
    end
    repeat (LAT) tick();
    exp_v = pack(1, 1, 1, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL request_latency: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = pack(1, 0, 1, 1);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL pulse_one_cycle: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_clear_priority();
    walkRequest_in = 1'b0;
    walkRegister_reset = 1'b1;
    tick();
    exp_v = pack(0, 0, 1, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL clear_basic: got %h want %h", obs, exp_v);
    end
    walkRequest_in = 1'b1;
    repeat (LAT) tick();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL clear_beats_request: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_capture();
    walkRegister_reset = 1'b0;
    tick();
    exp_v = pack(1, 1, 2, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL capture_after_clear: got %h want %h", obs, exp_v);
    end
    walkRequest_in = 1'b0;
    tick();
    exp_v = pack(1, 0, 2, 1);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL sticky_age1: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = pack(1, 0, 2, 2);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL sticky_age2: got %h want %h", obs, exp_v);
    end
    walkRequest_in = 1'b1;
    tick();
    exp_v = pack(1, 0, 2, 3);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL rerequest_no_pulse: got %h want %h", obs, exp_v);
    end
    walkRequest_in = 1'b0;
    repeat (LAT) tick();
    exp_v = pack(1, 0, 2, 3 + LAT);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL age_running: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_clear();
    walkRegister_reset = 1'b1;
    tick();
    exp_v = pack(0, 0, 2, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL clear_pending: got %h want %h", obs, exp_v);
    end
    repeat (LAT - 1) tick();
    walkRegister_reset = 1'b0;
    tick();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL idle_after_clear: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_count_saturation();
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      walkRegister_reset = 1'b0;
      walkRequest_in = 1'b1;
      repeat (LAT) tick();
      exp_v = pack(1, 1, ((3 + i) > 255) ? 255 : (3 + i), 0);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL count_step_%0d: got %h want %h", i, obs, exp_v);
      end
      walkRequest_in = 1'b0;
      walkRegister_reset = 1'b1;
      repeat (LAT) tick();
    end
    walkRegister_reset = 1'b0;
    tick();
    exp_v = pack(0, 0, 255, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL count_saturated: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_age_saturation();
    walkRequest_in = 1'b1;
    repeat (LAT) tick();
    walkRequest_in = 1'b0;
    exp_v = pack(1, 1, 255, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL age_set_edge: got %h want %h", obs, exp_v);
    end
    repeat (4094) tick();
    exp_v = pack(1, 0, 255, 4094);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL age_below_max: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = pack(1, 0, 255, 4095);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL age_at_max: got %h want %h", obs, exp_v);
    end
    repeat (6) tick();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL age_saturated: got %h want %h", obs, exp_v);
    end
    walkRegister_reset = 1'b1;
    repeat (LAT) tick();
    walkRegister_reset = 1'b0;
    exp_v = pack(0, 0, 255, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL age_clear: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_midflight();
    walkRequest_in = 1'b1;
    repeat (LAT) tick();
    exp_v = pack(1, 1, 255, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL pulse_before_reset: got %h want %h", obs, exp_v);
    end
    #2;
    sys_reset = 1'b0;
    #1;
    exp_v = pack(0, 0, 0, 0);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_kills_pulse: got %h want %h", obs, exp_v);
    end
    repeat (2) tick();
    walkRequest_in = 1'b0;
    sys_reset = 1'b1;
    repeat (LAT) tick();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_release_clean: got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clear_priority();
    test_capture();
    test_clear();
    test_count_saturation();
    test_age_saturation();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/walk_register.md
Name: walk_register

Overview:
- Pedestrian walk-request latch for the traffic light controller.
- Captures a push-button request and holds it as a sticky "pending walk" flag until the controller FSM clears it (after serving the walk phase).
- Also provides a set pulse, a saturating accepted-request counter, and a pending-age counter that the controller uses for priority decisions.

Parameters:
- CNT_W, 8, width of the accepted-request counter.
- AGE_W, 12, width of the pending-age counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- sys_reset  input  1  asynchronous, active-low system reset.
- walkRequest_in  input  1  walk button level; high = request.
- walkRegister_reset  input  1  synchronous clear from the controller; active-high.
- walkRegister_status  output  1  pending-walk flag.
- walkRegister_set  output  1  one-cycle pulse on the cycle the flag goes 0->1.
- walkRegister_count  output  CNT_W  number of accepted requests; saturating.
- walkRegister_age  output  AGE_W  cycles elapsed since the flag was set; saturating.

Behaviour:
- sys_reset low: immediately (asynchronously) status=0, set=0, count=0, age=0. Registers hold these values while sys_reset stays low.
- Effective request req_eff:
  - walkRequest_in directly by default.
  - Synchronized version when the optional feature is enabled.
- Flag update on each rising edge, with sys_reset high:
  - walkRegister_reset=1: status<=0. Clear wins over a simultaneous request.
  - Else if req_eff=1: status<=1. Level-sensitive, so a request held through a clear is captured on the first edge after the clear drops.
  - Else: status holds. Sticky; the button need not stay high.
- Latency: request high before edge N gives status=1 after edge N (1 cycle). Clear high before edge N gives status=0 after edge N.
- set: registered. 1 for exactly the cycle after the edge where status goes 0->1; 0 otherwise. Re-requests while already pending produce no pulse.
- count: increments by 1 on each 0->1 transition of status. Saturates at 2^CNT_W-1. Cleared only by sys_reset, not by walkRegister_reset.
- age:
  - 0 while status=0.
  - Set to 0 on the set edge.
  - Increments by 1 each cycle while status=1.
  - Saturates at 2^AGE_W-1.
  - Returns to 0 on the clear edge.
- All outputs are driven directly from registers; there is no combinational path from input to output.
- sys_reset asserted mid-operation: everything returns to reset values at once, including a set pulse in flight.

Optional Feature:
- Macro WALK_REGISTER_SYNC_EN.
- Defined:
  - walkRequest_in passes through a 2-flop synchronizer (reset to 0 by sys_reset) before the flag logic.
  - Request-to-status latency becomes 3 edges.
  - walkRegister_reset is unaffected and keeps its 1-edge latency.
- Undefined: no synchronizer; 1-edge latency as specified above.

Test Plan:
- sys_reset=0 with request=1 -> status=0, count=0, age=0 regardless of clocks. Release sys_reset=1 -> normal operation.
- walkRegister_reset=1 for 1 cycle -> status=0. Then walkRequest_in=1 with reset still 1 for 1 cycle -> status stays 0 (clear has priority).
- Drop walkRegister_reset while request=1 -> status=1 after next edge, set=1 for one cycle, count=1.
- walkRequest_in=0 for 1 cycle -> status stays 1. Age increments by 1 each cycle.
- walkRegister_reset=1 for 1 cycle -> status=0 and age=0 after the edge; count stays 1.
- Hold request=1 for 2^CNT_W+2 set/clear cycles -> count saturates at 2^CNT_W-1. Hold pending for 2^AGE_W+5 cycles -> age saturates at 2^AGE_W-1. With WALK_REGISTER_SYNC_EN defined, status rises 3 edges after request.
